// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared FSM state encoding and instruction memory geometry defaults.
package inst_loader_pkg;

    localparam int INSTMEM_ADDR_WIDTH = 8;
    localparam int INST_LENGTH        = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_ERROR
    } state_e;

endpackage

// File: rtl/inst_loader.sv
// inst_loader: streams a host program into instruction memory, then releases the core until it halts.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum check on the final beat.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W = INSTMEM_ADDR_WIDTH,
    parameter int INST_W = INST_LENGTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              host_valid,
    input  logic [INST_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [INST_W-1:0] imem_wr_data,
    output logic              core_reset,
    input  logic              core_halt,
    output logic              busy,
    output logic              done,
    output logic              error
`ifdef LOADER_CHECKSUM_EN
    ,
    input  logic [INST_W-1:0] exp_csum,
    output logic [INST_W-1:0] load_csum
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] data_q, data_d;
    logic              accept;
    logic              last_ok;

`ifdef LOADER_CHECKSUM_EN
    logic [INST_W-1:0] csum_q, csum_d;
    assign last_ok   = (csum_q ^ host_data) == exp_csum;
    assign load_csum = csum_q;
`else
    assign last_ok = 1'b1;
`endif

    assign accept       = (state_q == S_LOAD) && host_valid;
    assign host_ready   = state_q == S_LOAD;
    assign busy         = state_q == S_LOAD;
    assign core_reset   = state_q != S_RUN;
    assign done         = done_q;
    assign error        = err_q;
    assign imem_wr_en   = we_q;
    assign imem_wr_addr = addr_q;
    assign imem_wr_data = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        we_d    = accept;
        addr_d  = accept ? cnt_q : addr_q;
        data_d  = accept ? host_data : data_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (load_req) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q ^ host_data;
`endif
            // The last address may be written once; any beat beyond it is an overflow.
            if (host_last) begin
                state_d = last_ok ? S_RUN : S_ERROR;
                err_d   = !last_ok;
            end else if (&cnt_q) begin
                state_d = S_ERROR;
                err_d   = 1'b1;
            end
        end else if (state_q == S_RUN && core_halt) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) csum_q <= '0;
        else csum_q <= csum_d;
    end
`endif

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: drives an 8-bit-address and a 2-bit-address loader with the same host traffic
// and checks both against a behavioural model plus hand-computed write logs.
module tb_inst_loader;

    logic        clk = 0, reset = 0, load_req = 0, host_valid = 0, host_last = 0, core_halt = 0;
    logic [31:0] host_data = 0;
    logic        hr_a, we_a, cr_a, busy_a, done_a, err_a;
    logic        hr_b, we_b, cr_b, busy_b, done_b, err_b;
    logic [7:0]  wa_a;
    logic [1:0]  wa_b;
    logic [31:0] wd_a, wd_b;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] exp_csum = 0, cs_a, cs_b;
`endif

    int vecs = 0, errs = 0;
    logic [39:0] la[$], lb[$];
    logic [31:0] exp4[4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    inst_loader #(.ADDR_W(8), .INST_W(32)) dut_a (
        .clk(clk), .reset(reset), .load_req(load_req), .host_valid(host_valid),
        .host_data(host_data), .host_last(host_last), .host_ready(hr_a), .imem_wr_en(we_a),
        .imem_wr_addr(wa_a), .imem_wr_data(wd_a), .core_reset(cr_a), .core_halt(core_halt),
        .busy(busy_a), .done(done_a), .error(err_a)
`ifdef LOADER_CHECKSUM_EN
        , .exp_csum(exp_csum), .load_csum(cs_a)
`endif
    );

    inst_loader #(.ADDR_W(2), .INST_W(32)) dut_b (
        .clk(clk), .reset(reset), .load_req(load_req), .host_valid(host_valid),
        .host_data(host_data), .host_last(host_last), .host_ready(hr_b), .imem_wr_en(we_b),
        .imem_wr_addr(wa_b), .imem_wr_data(wd_b), .core_reset(cr_b), .core_halt(core_halt),
        .busy(busy_b), .done(done_b), .error(err_b)
`ifdef LOADER_CHECKSUM_EN
        , .exp_csum(exp_csum), .load_csum(cs_b)
`endif
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 loading, 2 running, 3 failed; capacity is the number of addresses.
    int          ph[2]    = '{0, 0};
    int          cnt[2]   = '{0, 0};
    int          cap[2]   = '{256, 4};
    bit          merr[2]  = '{0, 0};
    bit          mdone[2] = '{0, 0};
    bit          mwe[2]   = '{0, 0};
    int          maddr[2] = '{0, 0};
    logic [31:0] mdata[2] = '{0, 0};
    logic [31:0] mcsum[2] = '{0, 0};

    function automatic bit takes(int k);
        return ph[k] == 1 && host_valid;
    endfunction

    function automatic bit sum_ok(int k);
`ifdef LOADER_CHECKSUM_EN
        return (mcsum[k] ^ host_data) == exp_csum;
`else
        return k >= 0;
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                ph[k] <= 0; cnt[k] <= 0; merr[k] <= 0; mdone[k] <= 0;
                mwe[k] <= 0; maddr[k] <= 0; mdata[k] <= 0; mcsum[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                mwe[k]   <= takes(k);
                mdone[k] <= 0;
                if (takes(k)) begin
                    maddr[k] <= cnt[k];
                    mdata[k] <= host_data;
                end
                if (load_req) begin
                    ph[k] <= 1; cnt[k] <= 0; merr[k] <= 0; mcsum[k] <= 0;
                end else if (takes(k)) begin
                    cnt[k]   <= cnt[k] + 1;
                    mcsum[k] <= mcsum[k] ^ host_data;
                    if (host_last) begin
                        ph[k]   <= sum_ok(k) ? 2 : 3;
                        merr[k] <= !sum_ok(k);
                    end else if (cnt[k] == cap[k] - 1) begin
                        ph[k]   <= 3;
                        merr[k] <= 1;
                    end
                end else if (ph[k] == 2 && core_halt) begin
                    ph[k]    <= 0;
                    mdone[k] <= 1;
                end
            end
        end
    end

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("a_ready", hr_a, ph[0] == 1);
        chk("a_busy", busy_a, ph[0] == 1);
        chk("a_core_reset", cr_a, ph[0] != 2);
        chk("a_error", err_a, merr[0]);
        chk("a_done", done_a, mdone[0]);
        chk("a_wr_en", we_a, mwe[0]);
        chk("a_wr_addr", wa_a, maddr[0]);
        chk("a_wr_data", wd_a, mdata[0]);
        chk("b_ready", hr_b, ph[1] == 1);
        chk("b_busy", busy_b, ph[1] == 1);
        chk("b_core_reset", cr_b, ph[1] != 2);
        chk("b_error", err_b, merr[1]);
        chk("b_done", done_b, mdone[1]);
        chk("b_wr_en", we_b, mwe[1]);
        chk("b_wr_addr", wa_b, maddr[1]);
        chk("b_wr_data", wd_b, mdata[1]);
`ifdef LOADER_CHECKSUM_EN
        chk("a_csum", cs_a, mcsum[0]);
        chk("b_csum", cs_b, mcsum[1]);
`endif
        if (we_a) la.push_back({wa_a, wd_a});
        if (we_b) lb.push_back({6'b0, wa_b, wd_b});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(bit lr, bit v, logic [31:0] d, bit l, bit h);
        load_req = lr; host_valid = v; host_data = d; host_last = l; core_halt = h;
        step();
        load_req = 0; host_valid = 0; host_last = 0; core_halt = 0;
    endtask

    task automatic chk_four(string n);
        chk({n, "_a_count"}, la.size(), 4);
        chk({n, "_b_count"}, lb.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk({n, "_a_entry"}, la[i], {i[7:0], exp4[i]});
            chk({n, "_b_entry"}, lb[i], {i[7:0], exp4[i]});
        end
    endtask

    initial begin
        repeat (3) step();
        chk("rst_core_reset", cr_a, 1);
        chk("rst_ready", hr_a, 0);
        chk("rst_wr_en", we_a, 0);
        reset = 1;
        step();

        la.delete(); lb.delete();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, exp4[i], i == 3, 0);
        chk("run_core_reset_a", cr_a, 0);
        chk("run_core_reset_b", cr_b, 0);
        step();
        chk_four("plain");

        drive(0, 0, 0, 0, 1);
        chk("halt_done", done_a, 1);
        chk("halt_core_reset", cr_a, 1);
        step();
        chk("halt_done_drop", done_a, 0);

        la.delete(); lb.delete();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, exp4[i], i == 3, 0);
            drive(0, 0, 32'hDEAD, 0, 0);
        end
        chk_four("gapped");

        drive(1, 0, 0, 0, 1);
        chk("halt_vs_load_done", done_a, 0);
        chk("halt_vs_load_busy", busy_a, 1);
        step();
        chk("halt_vs_load_done2", done_a, 0);

        la.delete(); lb.delete();
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 32'hA0 + i, 0, 0);
        step();
        chk("ovf_error", err_b, 1);
        chk("ovf_core_reset", cr_b, 1);
        chk("ovf_busy", busy_b, 0);
        chk("ovf_b_count", lb.size(), 4);
        chk("ovf_b_last", lb[3], {8'd3, 32'hA3});
        chk("ovf_a_count", la.size(), 5);
        drive(0, 1, 32'h99, 1, 0);
        chk("err_sticky", err_b, 1);
        chk("a_run_after_last", cr_a, 0);

        drive(1, 0, 0, 0, 0);
        chk("err_cleared", err_b, 0);
        la.delete(); lb.delete();
        drive(0, 1, 32'h55, 0, 0);
        host_valid = 1; host_data = 32'h66;
        @(negedge clk);
        #1 reset = 0;
        #1;
        chk("arst_wr_en", we_a, 0);
        chk("arst_wr_addr", wa_a, 0);
        chk("arst_wr_data", wd_a, 0);
        chk("arst_core_reset", cr_a, 1);
        chk("arst_ready", hr_a, 0);
        chk("arst_busy", busy_a, 0);
        step(); step();
        host_valid = 0;
        reset = 1;
        drive(0, 1, 32'h77, 0, 0);
        drive(0, 1, 32'h78, 1, 0);
        step();
        chk("arst_writes", la.size(), 1);
        chk("arst_first", la[0], {8'd0, 32'h55});
        chk("arst_idle", busy_a, 0);

`ifdef LOADER_CHECKSUM_EN
        exp_csum = 32'hFF;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 32'hF0, 0, 0);
        drive(0, 1, 32'h0F, 1, 0);
        chk("csum_ok_run", cr_a, 0);
        chk("csum_ok_err", err_a, 0);
        chk("csum_value", cs_a, 32'hFF);
        exp_csum = 32'h00;
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 32'hF0, 0, 0);
        drive(0, 1, 32'h0F, 1, 0);
        chk("csum_bad_err", err_a, 1);
        chk("csum_bad_core_reset", cr_a, 1);
        chk("csum_bad_busy", busy_a, 0);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction memory address width (matches INSTMEM_ADDR_WIDTH).
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction word width (matches INST_LENGTH).
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_req  input  1  single-cycle pulse; starts a program load session.
REQ-006 host_valid  input  1  host word valid.
REQ-007 host_data  input  INST_W  host instruction word.
REQ-008 host_last  input  1  marks final word of the program.
REQ-009 host_ready  output  1  loader accepts a word this cycle.
REQ-010 imem_wr_en  output  1  instruction memory write strobe.
REQ-011 imem_wr_addr  output  ADDR_W  instruction memory write address.
REQ-012 imem_wr_data  output  INST_W  instruction memory write data.
REQ-013 core_reset  output  1  active-high reset to the SM core; held while not running.
REQ-014 core_halt  input  1  core reports program end.
REQ-015 busy  output  1  high in LOAD.
REQ-016 done  output  1  one-cycle pulse when the core halts.
REQ-017 error  output  1  sticky load failure flag; cleared by the next load_req.

Function
REQ-018 FSM states IDLE, LOAD, RUN, ERROR; state encoding is a shared enum.
REQ-019 IDLE: core_reset=1, host_ready=0; load_req -> LOAD, write address counter := 0, error := 0.
REQ-020 LOAD: host_ready=1; a beat is accepted when host_valid and host_ready are both high.
REQ-021 Accepted beat: imem_wr_en=1, imem_wr_addr=counter, imem_wr_data=host_data, all registered, so they are visible exactly 1 cycle after the beat; counter increments by 1.
REQ-022 Accepted beat with host_last=1: written normally, then next state is RUN; no further beats are accepted.
REQ-023 Overflow: a beat accepted at counter = 2^ADDR_W-1 with host_last=0 is written, then error := 1 and the FSM moves to ERROR; the counter never wraps into a second write at address 0.
REQ-024 RUN: core_reset=0 from the first RUN cycle; host_ready=0; core_halt=1 -> IDLE with done pulsed for exactly one cycle.
REQ-025 load_req in RUN: core_reset reasserts the next cycle, the FSM goes to LOAD with counter := 0, and done is not pulsed.
REQ-026 load_req in LOAD: restarts the load with counter := 0; words already written are not erased.
REQ-027 ERROR: core_reset=1, host_ready=0; only load_req leaves ERROR, going to LOAD.
REQ-028 load_req coincident with core_halt in RUN: load_req wins and done is not pulsed.
REQ-029 imem_wr_en SHALL be 0 in every cycle without an accepted beat in the previous cycle.

Reset
REQ-030 reset low forces, asynchronously, state=IDLE, counter=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, core_reset=1, host_ready=0, busy=0, done=0, error=0.
REQ-031 Reset asserted mid-LOAD aborts the load with no further writes; after release the FSM waits in IDLE for load_req.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN adds input exp_csum [INST_W] and output load_csum [INST_W].
REQ-033 With the macro: load_csum is the running XOR of the words written since load_req, reset to 0.
REQ-034 With the macro: on the host_last beat, exp_csum is compared with the final XOR value; a mismatch goes to ERROR instead of RUN, with error=1 and core_reset held at 1.
REQ-035 Without the macro: the two ports and the checksum logic are absent, and host_last always goes to RUN.

Structure
REQ-036 Shared package holds the FSM state enum and the ADDR_W/INST_W defaults tied to INSTMEM_ADDR_WIDTH/INST_LENGTH.
REQ-037 No sub-modules; the FSM, counter and checksum are one module.

Verification
REQ-038 Reset, then load_req, then 4 beats 0x11,0x22,0x33,0x44 with last on beat 4 -> writes addr 0..3 each 1 cycle after its beat; core_reset falls the cycle after the RUN entry edge.
REQ-039 Same load with host_valid toggling 1/0 -> identical writes; no write strobe in gap cycles.
REQ-040 ADDR_W=2, 5 beats with no last -> writes to addr 0..3 only, error=1, state ERROR, core_reset=1.
REQ-041 In RUN, pulse core_halt -> done high for exactly 1 cycle, core_reset=1, IDLE; core_halt and load_req together -> no done, state LOAD.
REQ-042 reset low during beat 2 of 4 -> all outputs at reset values immediately; no write for beat 2.
REQ-043 LOADER_CHECKSUM_EN defined, words 0xF0,0x0F with exp_csum=0xFF -> RUN; same words with exp_csum=0x00 -> ERROR, error=1.
